// File: rtl/sdp_bram_fifo.sv
// sdp_bram_fifo: show-ahead FIFO over a simple dual-port BRAM with a prefetched head entry
// Ports: clk, rst (async, active-high), clr (sync flush); push/push_data/full on the write side;
// pop/pop_data/empty on the read side; count = RAM entries + prefetched head;
// overflow/underflow sticky errors, built only when SDP_BRAM_FIFO_ERR_EN is defined (else tied 0).
module sdp_bram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

module sdp_bram_fifo #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  logic [ADDR_WIDTH:0] wptr, rptr, ram_cnt;
  logic out_valid, do_push, do_read;
  assign ram_cnt = wptr - rptr;
  assign full = ram_cnt == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign empty = !out_valid;
  assign count = ram_cnt + {{ADDR_WIDTH{1'b0}}, out_valid};
  // a flush discards any same-cycle push or read so nothing leaks past it
  assign do_push = push & !full & !clr;
  // refill the head whenever it is absent or being consumed; ram_cnt != 0 keeps reads off the write address
  assign do_read = (ram_cnt != '0) & (!out_valid | pop) & !clr;
  sdp_bram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk),
    .we(do_push),
    .wa(wptr[ADDR_WIDTH-1:0]),
    .wd(push_data),
    .re(do_read),
    .ra(rptr[ADDR_WIDTH-1:0]),
    .rd(pop_data)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      out_valid <= 1'b0;
    end else begin
      wptr <= wptr + {{ADDR_WIDTH{1'b0}}, do_push};
      rptr <= rptr + {{ADDR_WIDTH{1'b0}}, do_read};
      out_valid <= do_read | (out_valid & !pop);
    end
  end
`ifdef SDP_BRAM_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= overflow | (push & full);
      underflow <= underflow | (pop & empty);
    end
  end
`else
  assign overflow = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sdp_bram_fifo.sv
// tb_sdp_bram_fifo: directed self-checking bench for sdp_bram_fifo with a 4-entry RAM
module tb_sdp_bram_fifo;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0, push = 1'b0, pop = 1'b0;
  logic [7:0] push_data = '0, pop_data;
  logic full, empty, overflow, underflow;
  logic [2:0] count;
  int vectors = 0, miscompares = 0;
`ifdef SDP_BRAM_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  sdp_bram_fifo #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .push_data(push_data), .full(full),
    .pop(pop), .pop_data(pop_data), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_one(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    tick;
    push = 1'b0;
  endtask
  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_empty", 16'(empty), 16'd1);
    chk("rst_full", 16'(full), 16'd0);
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_udf", 16'(underflow), 16'd0);
    // fill: 0x01..0x06 back to back, 0x06 dropped
    push_one(8'h01);
    chk("fill_lat1_empty", 16'(empty), 16'd1);
    for (int i = 2; i <= 6; i++) begin
      push_one(8'(i));
      if (i == 2) begin
        chk("fill_lat2_empty", 16'(empty), 16'd0);
        chk("fill_head", 16'(pop_data), 16'h01);
      end
      if (i == 5) chk("fill_cnt5", 16'(count), 16'd5);
    end
    chk("fill_full", 16'(full), 16'd1);
    chk("fill_count", 16'(count), 16'd5);
    pop = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("drain_data", 16'(pop_data), 16'(i));
      chk("drain_empty", 16'(empty), 16'd0);
      tick;
    end
    pop = 1'b0;
    chk("drain_done_empty", 16'(empty), 16'd1);
    chk("drain_done_count", 16'(count), 16'd0);
    // full corner: push while full with pop is dropped
    for (int i = 0; i < 5; i++) push_one(8'(8'h10 + i));
    chk("corner_full", 16'(full), 16'd1);
    push = 1'b1;
    push_data = 8'hAA;
    pop = 1'b1;
    tick;
    push = 1'b0;
    pop = 1'b0;
    chk("corner_count", 16'(count), 16'd4);
    chk("corner_notfull", 16'(full), 16'd0);
    chk("corner_ovf", 16'(overflow), 16'(ERR));
    pop = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("corner_data", 16'(pop_data), 16'(8'h10 + i));
      tick;
    end
    pop = 1'b0;
    chk("corner_empty", 16'(empty), 16'd1);
    // streaming: push and pop every cycle from count=2
    push_one(8'h20);
    push_one(8'h21);
    chk("stream_start", 16'(count), 16'd2);
    push = 1'b1;
    pop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_data = 8'(8'h22 + i);
      chk("stream_data", 16'(pop_data), 16'(8'h20 + i));
      tick;
      chk("stream_count", 16'(count), 16'd2);
    end
    push = 1'b0;
    chk("stream_tail0", 16'(pop_data), 16'h34);
    tick;
    chk("stream_tail1", 16'(pop_data), 16'h35);
    tick;
    pop = 1'b0;
    chk("stream_empty", 16'(empty), 16'd1);
    // clr with a concurrent push
    push_one(8'h40);
    push_one(8'h41);
    push_one(8'h42);
    chk("clr_pre_count", 16'(count), 16'd3);
    clr = 1'b1;
    push = 1'b1;
    push_data = 8'h99;
    tick;
    clr = 1'b0;
    push = 1'b0;
    chk("clr_count", 16'(count), 16'd0);
    chk("clr_empty", 16'(empty), 16'd1);
    tick;
    tick;
    chk("clr_still_empty", 16'(empty), 16'd1);
    push_one(8'h77);
    tick;
    chk("clr_after_data", 16'(pop_data), 16'h77);
    chk("clr_after_count", 16'(count), 16'd1);
    pop = 1'b1;
    tick;
    pop = 1'b0;
    chk("clr_after_empty", 16'(empty), 16'd1);
    // underflow: sticky until clr
    pop = 1'b1;
    tick;
    pop = 1'b0;
    chk("udf_set", 16'(underflow), 16'(ERR));
    chk("udf_nochange", 16'(count), 16'd0);
    tick;
    chk("udf_sticky", 16'(underflow), 16'(ERR));
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("udf_clr", 16'(underflow), 16'd0);
    chk("ovf_clr", 16'(overflow), 16'd0);
    // async reset mid-stream with 5 entries held
    for (int i = 0; i < 5; i++) push_one(8'(8'h60 + i));
    chk("rst2_pre_count", 16'(count), 16'd5);
    #2 rst = 1'b1;
    #1;
    chk("rst2_empty", 16'(empty), 16'd1);
    chk("rst2_full", 16'(full), 16'd0);
    chk("rst2_count", 16'(count), 16'd0);
    #1 rst = 1'b0;
    tick;
    push_one(8'h5A);
    chk("rst2_lat1_empty", 16'(empty), 16'd1);
    tick;
    chk("rst2_lat2_empty", 16'(empty), 16'd0);
    chk("rst2_data", 16'(pop_data), 16'h5A);
    chk("rst2_count1", 16'(count), 16'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
